// File: rtl/hazard_pkg.sv
// Shared types and control-output encodings for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_IDLE       = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_MC_WAIT    = 2'd2
  } hazard_state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                         if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0};
  localparam pipe_ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1,
                                         if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b0};
  localparam pipe_ctrl_t CTRL_HOLD   = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                                         if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b1};
  localparam pipe_ctrl_t CTRL_SQUASH = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                         if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b0};
  // Everything frozen and flushed while the core is held in reset.
  localparam pipe_ctrl_t CTRL_RESET  = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                                         if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: flags an ID source that reads the
// destination of a load currently in EX. Register x0 never hazards.
module load_use_detect #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2
) (
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_id,
  input  logic [NUM_SRC-1:0]            rs_used_id,
  input  logic [REG_ADDR_W-1:0]         rd_ex,
  input  logic                          mem_read_ex,
  output logic                          lu
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    lu = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_used_id[i] && (rs_id[i*REG_ADDR_W +: REG_ADDR_W] == rd_ex)) lu = 1'b1;
    end
    if (!mem_read_ex || (rd_ex == '0)) lu = 1'b0;
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, multi-cycle EX holds, redirect squash.
// Optional multi-cycle watchdog enabled by defining HAZARD_MC_TIMEOUT_EN.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int NUM_SRC           = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MC_TIMEOUT        = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_id,
  input  logic [NUM_SRC-1:0]            rs_used_id,
  input  logic [REG_ADDR_W-1:0]         rd_ex,
  input  logic                          mem_read_ex,
  input  logic                          mc_start,
  input  logic                          mc_done,
  input  logic                          redirect,
  output logic                          pc_write,
  output logic                          if_id_write,
  output logic                          id_ex_write,
  output logic                          if_id_flush,
  output logic                          id_ex_flush,
  output logic                          ex_mem_flush,
  output logic                          busy,
  output logic                          mc_timeout
);

  localparam int LU_W = $clog2(LOAD_STALL_CYCLES + 1);

  hazard_state_t   state, state_n;
  logic [LU_W-1:0] lu_cnt, lu_cnt_n;
  logic            lu;
  logic            wd_expire;
  logic            timeout_c;
  pipe_ctrl_t      ctrl;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_SRC    (NUM_SRC)
  ) u_load_use_detect (
    .rs_id       (rs_id),
    .rs_used_id  (rs_used_id),
    .rd_ex       (rd_ex),
    .mem_read_ex (mem_read_ex),
    .lu          (lu)
  );

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state  <= HZ_IDLE;
      lu_cnt <= '0;
    end else begin
      state  <= state_n;
      lu_cnt <= lu_cnt_n;
    end
  end

`ifdef HAZARD_MC_TIMEOUT_EN
  localparam int WD_W = $clog2(MC_TIMEOUT + 1);
  logic [WD_W-1:0] mc_wd;

  // mc_wd holds the number of MC_WAIT cycles already elapsed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    mc_wd <= '0;
    else if (state != HZ_MC_WAIT) mc_wd <= '0;
    else                          mc_wd <= mc_wd + 1'b1;
  end

  assign wd_expire = (state == HZ_MC_WAIT) && (mc_wd == WD_W'(MC_TIMEOUT - 1));
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    ctrl      = CTRL_NORMAL;
    state_n   = state;
    lu_cnt_n  = lu_cnt;
    timeout_c = 1'b0;
    unique case (state)
      HZ_IDLE: begin
        if (redirect) begin
          ctrl = CTRL_SQUASH;
        end else if (mc_start && mc_done) begin
          ctrl = CTRL_NORMAL;
        end else if (mc_start) begin
          ctrl    = CTRL_HOLD;
          state_n = HZ_MC_WAIT;
        end else if (lu) begin
          ctrl = CTRL_BUBBLE;
          if (LOAD_STALL_CYCLES > 1) begin
            state_n  = HZ_LOAD_STALL;
            lu_cnt_n = LU_W'(LOAD_STALL_CYCLES - 1);
          end
        end
      end
      HZ_LOAD_STALL: begin
        if (redirect) begin
          ctrl     = CTRL_SQUASH;
          state_n  = HZ_IDLE;
          lu_cnt_n = '0;
        end else begin
          ctrl     = CTRL_BUBBLE;
          lu_cnt_n = lu_cnt - 1'b1;
          if (lu_cnt == LU_W'(1)) state_n = HZ_IDLE;
        end
      end
      HZ_MC_WAIT: begin
        if (mc_done) begin
          ctrl    = CTRL_NORMAL;
          state_n = HZ_IDLE;
        end else if (wd_expire) begin
          ctrl      = CTRL_NORMAL;
          timeout_c = 1'b1;
          state_n   = HZ_IDLE;
        end else begin
          ctrl = CTRL_HOLD;
        end
      end
      default: state_n = HZ_IDLE;
    endcase
    // Reset overrides the outputs combinationally, without waiting for a clock.
    if (reset) begin
      ctrl      = CTRL_RESET;
      timeout_c = 1'b0;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign id_ex_write  = ctrl.id_ex_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign busy         = (state != HZ_IDLE);
  assign mc_timeout   = timeout_c;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three instances (LOAD_STALL_CYCLES=1,2,3) driven in
// parallel, directed literal checks plus random stimulus against a behavioural model.
module tb_hazard_ctrl_unit;

  localparam int AW = 5;
  localparam int NS = 3;
  localparam int TO = 4;
  localparam int ND = 3;
`ifdef HAZARD_MC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Observation vector: {pc_w, if_id_w, id_ex_w, if_id_fl, id_ex_fl, ex_mem_fl, busy, mc_timeout}
  localparam logic [7:0] E_NORMAL = 8'b111_000_00;
  localparam logic [7:0] E_BUBBLE = 8'b001_010_00;
  localparam logic [7:0] E_HOLD   = 8'b000_001_00;
  localparam logic [7:0] E_SQUASH = 8'b111_110_00;
  localparam logic [7:0] E_RESET  = 8'b000_111_00;
  localparam logic [7:0] B_BUSY   = 8'b000_000_10;
  localparam logic [7:0] B_TO     = 8'b000_000_01;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NS*AW-1:0]  rs_id = '0;
  logic [NS-1:0]     rs_used_id = '0;
  logic [AW-1:0]     rd_ex = '0;
  logic              mem_read_ex = 1'b0;
  logic              mc_start = 1'b0;
  logic              mc_done = 1'b0;
  logic              redirect = 1'b0;
  logic [ND-1:0][7:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic pw, iw, ew, ifl, efl, mfl, bsy, tmo;
    hazard_ctrl_unit #(
      .REG_ADDR_W        (AW),
      .NUM_SRC           (NS),
      .LOAD_STALL_CYCLES (g + 1),
      .MC_TIMEOUT        (TO)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .rs_id        (rs_id),
      .rs_used_id   (rs_used_id),
      .rd_ex        (rd_ex),
      .mem_read_ex  (mem_read_ex),
      .mc_start     (mc_start),
      .mc_done      (mc_done),
      .redirect     (redirect),
      .pc_write     (pw),
      .if_id_write  (iw),
      .id_ex_write  (ew),
      .if_id_flush  (ifl),
      .id_ex_flush  (efl),
      .ex_mem_flush (mfl),
      .busy         (bsy),
      .mc_timeout   (tmo)
    );
    assign obs[g] = {pw, iw, ew, ifl, efl, mfl, bsy, tmo};
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Behavioural model: bubbles still owed, whether a multi-cycle op is pending, and its age.
  int stall_left [ND];
  bit mc_wait    [ND];
  int mc_age     [ND];
  int stall_nx   [ND];
  bit wait_nx    [ND];
  int age_nx     [ND];

  initial begin
    for (int d = 0; d < ND; d++) begin
      stall_left[d] = 0; mc_wait[d] = 1'b0; mc_age[d] = 0;
      stall_nx[d]   = 0; wait_nx[d] = 1'b0; age_nx[d] = 0;
    end
  end

  function automatic bit hazard_now();
    bit h = 1'b0;
    for (int i = 0; i < NS; i++)
      if (rs_used_id[i] && rs_id[i*AW +: AW] == rd_ex) h = 1'b1;
    return h && mem_read_ex && (rd_ex != 0);
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      logic [7:0] e;
      int ns, na;
      bit nw;
      ns = stall_left[d]; nw = mc_wait[d]; na = mc_age[d];
      if (reset) begin
        e = E_RESET; ns = 0; nw = 1'b0; na = 0;
      end else if (mc_wait[d]) begin
        na = mc_age[d] + 1;
        if (mc_done) begin
          e = E_NORMAL | B_BUSY; nw = 1'b0;
        end else if (TO_EN && na == TO) begin
          e = E_NORMAL | B_BUSY | B_TO; nw = 1'b0;
        end else begin
          e = E_HOLD | B_BUSY;
        end
      end else if (stall_left[d] > 0) begin
        if (redirect) begin
          e = E_SQUASH | B_BUSY; ns = 0;
        end else begin
          e = E_BUBBLE | B_BUSY; ns = stall_left[d] - 1;
        end
      end else begin
        if (redirect)                e = E_SQUASH;
        else if (mc_start && mc_done) e = E_NORMAL;
        else if (mc_start) begin     e = E_HOLD; nw = 1'b1; na = 0; end
        else if (hazard_now()) begin e = E_BUBBLE; ns = d; end
        else                         e = E_NORMAL;
      end
      check($sformatf("model_l%0d", d + 1), obs[d], e);
      stall_nx[d] = ns; wait_nx[d] = nw; age_nx[d] = na;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      stall_left[d] = stall_nx[d]; mc_wait[d] = wait_nx[d]; mc_age[d] = age_nx[d];
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic idle_inputs();
    rs_id = '0; rs_used_id = '0; rd_ex = '0; mem_read_ex = 1'b0;
    mc_start = 1'b0; mc_done = 1'b0; redirect = 1'b0;
  endtask

  task automatic load_use_5();
    mem_read_ex = 1'b1; rd_ex = 5'd5; rs_id = '0; rs_id[AW-1:0] = 5'd5; rs_used_id = 3'b001;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", obs[1], E_RESET);
    reset = 1'b0;
    sample(); check("after_reset", obs[1], E_NORMAL);

    // Load-use on src0 = x5.
    tick(); load_use_5();
    sample(); check("lu_c1_l1", obs[0], E_BUBBLE); check("lu_c1_l2", obs[1], E_BUBBLE);
    tick(); idle_inputs();
    sample(); check("lu_c2_l1", obs[0], E_NORMAL); check("lu_c2_l2", obs[1], E_BUBBLE | B_BUSY);
    check("lu_c2_l3", obs[2], E_BUBBLE | B_BUSY);
    tick();
    sample(); check("lu_c3_l2", obs[1], E_NORMAL); check("lu_c3_l3", obs[2], E_BUBBLE | B_BUSY);
    tick();
    sample(); check("lu_c4_l3", obs[2], E_NORMAL);

    // No hazard: x0 destination, and matching source not used.
    tick(); mem_read_ex = 1'b1; rd_ex = '0; rs_used_id = 3'b001;
    sample(); check("lu_x0", obs[1], E_NORMAL);
    tick(); rd_ex = 5'd7; rs_id = '0; rs_id[AW-1:0] = 5'd3; rs_id[2*AW-1:AW] = 5'd7; rs_used_id = 3'b001;
    sample(); check("lu_unused_src", obs[1], E_NORMAL);

    // Multi-cycle op, done three cycles after start.
    tick(); idle_inputs(); mc_start = 1'b1;
    sample(); check("mc_c0", obs[1], E_HOLD);
    tick(); mc_start = 1'b0;
    sample(); check("mc_c1", obs[1], E_HOLD | B_BUSY);
    tick();
    sample(); check("mc_c2", obs[1], E_HOLD | B_BUSY);
    tick(); mc_done = 1'b1;
    sample(); check("mc_done", obs[1], E_NORMAL | B_BUSY);
    tick(); mc_done = 1'b0;
    sample(); check("mc_after", obs[1], E_NORMAL);

    // Redirect during the second stall cycle.
    tick(); load_use_5();
    sample(); check("rd_c1_l3", obs[2], E_BUBBLE);
    tick(); idle_inputs(); redirect = 1'b1;
    sample(); check("rd_squash_l3", obs[2], E_SQUASH | B_BUSY);
    tick(); redirect = 1'b0;
    sample(); check("rd_after_l3", obs[2], E_NORMAL);

    // Reset pulsed in MC_WAIT.
    tick(); mc_start = 1'b1;
    sample();
    tick(); mc_start = 1'b0;
    sample(); check("rst_mc_hold", obs[1], E_HOLD | B_BUSY);
    tick(); reset = 1'b1;
    #1 check("rst_mc_immediate", obs[1], E_RESET);
    tick(); reset = 1'b0;
    sample(); check("rst_mc_release", obs[1], E_NORMAL);

    // Watchdog: no mc_done.
    tick(); mc_start = 1'b1;
    sample();
    tick(); mc_start = 1'b0;
    for (int i = 1; i < TO; i++) begin
      sample(); check($sformatf("wd_hold_%0d", i), obs[1], E_HOLD | B_BUSY);
      tick();
    end
    sample();
`ifdef HAZARD_MC_TIMEOUT_EN
    check("wd_pulse", obs[1], E_NORMAL | B_BUSY | B_TO);
    tick();
    sample(); check("wd_after", obs[1], E_NORMAL);
`else
    check("wd_disabled_hold", obs[1], E_HOLD | B_BUSY);
    tick(); mc_done = 1'b1;
    sample(); check("wd_disabled_done", obs[1], E_NORMAL | B_BUSY);
    tick(); mc_done = 1'b0;
    sample(); check("wd_disabled_after", obs[1], E_NORMAL);
`endif

    // Random phase; redirect/mc_start are kept legal while any op is pending.
    for (int c = 0; c < 4000; c++) begin
      bit pending;
      tick();
      pending = 1'b0;
      for (int d = 0; d < ND; d++) if (mc_wait[d]) pending = 1'b1;
      reset       = ($urandom_range(0, 199) == 0);
      rd_ex       = AW'($urandom_range(0, 7));
      for (int i = 0; i < NS; i++) rs_id[i*AW +: AW] = AW'($urandom_range(0, 7));
      rs_used_id  = NS'($urandom_range(0, 7));
      mem_read_ex = $urandom_range(0, 1) == 1;
      mc_done     = $urandom_range(0, 5) == 0;
      mc_start    = !pending && ($urandom_range(0, 9) == 0);
      redirect    = !pending && ($urandom_range(0, 11) == 0);
    end

    tick(); idle_inputs(); reset = 1'b0;
    sample();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage RISC-V core. It generalises load-use stalling to N source operands and multi-cycle load latency. It also holds the pipeline for variable-latency EX operations (mc_start/mc_done handshake) and squashes IF/ID and ID/EX on a control-flow redirect resolved in EX. All pipeline-register write and flush enables are driven from a small FSM.

## Interface
- REG_ADDR_W, 5, register-index width
- NUM_SRC, 2, source operands checked per ID instruction (2 or 3)
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (>=1)
- MC_TIMEOUT, 64, watchdog limit in MC_WAIT cycles (used only with the macro)

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- rs_id  in  NUM_SRC*REG_ADDR_W  packed ID source indices, src0 in LSBs
- rs_used_id  in  NUM_SRC  per-source valid
- rd_ex  in  REG_ADDR_W  destination of the EX instruction
- mem_read_ex  in  1  EX instruction is a load
- mc_start  in  1  EX instruction is a multi-cycle op, first EX cycle
- mc_done  in  1  multi-cycle unit result valid
- redirect  in  1  taken branch/jump resolved in EX
- pc_write, if_id_write, id_ex_write  out  1  register enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  insert bubble into that register
- busy  out  1  state != HZ_IDLE
- mc_timeout  out  1  one-cycle watchdog pulse

## Operation
- States: HZ_IDLE, HZ_LOAD_STALL, HZ_MC_WAIT. lu_cnt width is $clog2(LOAD_STALL_CYCLES+1).
- Load-use hazard (lu): mem_read_ex && rd_ex!=0 && any i with rs_used_id[i] && rs_id[i]==rd_ex.
- Output sets:
  - NORMAL: writes=1, flushes=0.
  - BUBBLE: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1.
  - HOLD: pc/if_id/id_ex writes=0, ex_mem_flush=1.
  - SQUASH: writes=1, if_id_flush=1, id_ex_flush=1.
- HZ_IDLE, priority redirect > mc_start > lu:
  - redirect: SQUASH, stay. mc_start and lu are ignored.
  - mc_start && mc_done: NORMAL, stay.
  - mc_start: HOLD, go to HZ_MC_WAIT.
  - lu: BUBBLE. If LOAD_STALL_CYCLES>1, go to HZ_LOAD_STALL with lu_cnt=LOAD_STALL_CYCLES-1.
  - otherwise: NORMAL.
- HZ_LOAD_STALL:
  - redirect: SQUASH, go to HZ_IDLE.
  - else: BUBBLE and decrement lu_cnt. When lu_cnt==1, go to HZ_IDLE.
  - lu is not re-evaluated.
- HZ_MC_WAIT:
  - mc_done=0: HOLD.
  - mc_done=1: NORMAL, go to HZ_IDLE.
  - redirect and mc_start are ignored here (protocol violation, flagged by bench assertion).
- rs index 0 never hazards. Unused source bits are don't-care.

## Timing
- Outputs are combinational from state and inputs. State and counters update on the rising clk edge.
- While reset=1: state HZ_IDLE, counters 0.
  - Outputs forced: pc_write=0, if_id_write=0, id_ex_write=0, all flushes=1, busy=0, mc_timeout=0.
- Load-use latency: exactly LOAD_STALL_CYCLES BUBBLE cycles, starting in the detection cycle. NORMAL resumes the next cycle.
- Multi-cycle op whose mc_done arrives k cycles after mc_start (k>=1): k HOLD cycles, then NORMAL in the mc_done cycle.
- Reset asserted mid-stall aborts immediately. The first cycle after release is HZ_IDLE.

## Configuration
- HAZARD_MC_TIMEOUT_EN defined:
  - mc_wd counter is cleared on entry to HZ_MC_WAIT and counts each HZ_MC_WAIT cycle.
  - In the MC_TIMEOUT-th HZ_MC_WAIT cycle without mc_done: mc_timeout=1, NORMAL, go to HZ_IDLE.
  - mc_done in that same cycle wins; no pulse.
- Not defined: no mc_wd counter, mc_timeout tied 0, HZ_MC_WAIT waits indefinitely.

## Structure
- hazard_pkg holds:
  - hazard_state_t enum (HZ_IDLE, HZ_LOAD_STALL, HZ_MC_WAIT)
  - pipe_ctrl_t struct bundling the six enables
  - localparam constants for NORMAL/BUBBLE/HOLD/SQUASH
- Sub-module load_use_detect: combinational, parametrised by REG_ADDR_W and NUM_SRC, outputs lu.

## Test plan
- LOAD_STALL_CYCLES=2; load rd_ex=5, rs_id[0]=5 used → 2 cycles of pc_write=0, id_ex_flush=1, busy=1 in the second; third cycle NORMAL.
- Load rd_ex=0 with rs_id[0]=0, and load rd_ex=7 with the matching source unused → NORMAL, no stall.
- mc_start, mc_done 3 cycles later → id_ex_write=0, ex_mem_flush=1 for 3 cycles; NORMAL on the done cycle; busy drops the next cycle.
- LOAD_STALL_CYCLES=3; redirect in the second stall cycle → if_id_flush=1, id_ex_flush=1, pc_write=1 that cycle; HZ_IDLE next.
- reset pulsed mid HZ_MC_WAIT → outputs forced to reset values immediately; NORMAL after release with mc_done=0.
- HAZARD_MC_TIMEOUT_EN, MC_TIMEOUT=4, no mc_done → mc_timeout=1 in the 4th HZ_MC_WAIT cycle only; HZ_IDLE after.
